// File: rtl/hazard_stall_if.sv
// Hazard/sequencing bundle between the pipeline and hazard_stall_ctrl.
// The master side is the pipeline; the slave side is the controller.
interface hazard_stall_if #(
   parameter int CNT_W = 16
);
   logic             IDEXMemRead;
   logic [4:0]       IDEXRegisterRt;
   logic [4:0]       IFIDRegisterRs;
   logic [4:0]       IFIDRegisterRt;
   logic             IFIDUsesRt;
   logic             branchTaken;
   logic             IDEXMdStart;
   logic             pcWrite;
   logic             IFIDWrite;
   logic             IFIDFlush;
   logic             IDEXWrite;
   logic             IDEXBubble;
   logic             EXMEMBubble;
   logic             mdBusy;
   logic             hiloWrite;
   logic [CNT_W-1:0] stallCount;

   modport master (
      output IDEXMemRead, IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt,
             IFIDUsesRt, branchTaken, IDEXMdStart,
      input  pcWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
             EXMEMBubble, mdBusy, hiloWrite, stallCount
   );

   modport slave (
      input  IDEXMemRead, IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt,
             IFIDUsesRt, branchTaken, IDEXMdStart,
      output pcWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
             EXMEMBubble, mdBusy, hiloWrite, stallCount
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, branch flush and mult/div front-end freeze for the 5-stage MIPS core.
// Outputs are combinational from the IDLE/BUSY state, the latency counter and the hazard inputs.
module hazard_stall_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_stall_if.slave hz
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

   state_t           state;
   logic [3:0]       cnt;
   logic [CNT_W-1:0] stall_count;

   logic freeze;
   logic load_use;
   logic pc_write;
   logic ifid_write;
   logic ifid_flush;
   logic idex_write;
   logic idex_bubble;
   logic exmem_bubble;
   logic hilo_write;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Everything is masked while rst is held so the pipeline runs freely out of reset.
   always_comb begin
      freeze = !rst && (((state == IDLE) && hz.IDEXMdStart) ||
                        ((state == BUSY) && (cnt != 4'd0)));
      load_use = !rst && hz.IDEXMemRead && (hz.IDEXRegisterRt != 5'd0) &&
                 ((hz.IDEXRegisterRt == hz.IFIDRegisterRs) ||
                  (hz.IFIDUsesRt && (hz.IDEXRegisterRt == hz.IFIDRegisterRt)));
      hilo_write   = !rst && (state == BUSY) && (cnt == 4'd0);
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      if (freeze) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
      end else if (load_use) begin
         // A taken branch in the stalled ID slot is re-evaluated next cycle.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (hz.branchTaken && !rst) begin
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         stall_count <= '0;
      end else begin
         if (state == IDLE) begin
            if (hz.IDEXMdStart) begin
               state <= BUSY;
               cnt   <= MD_INIT;
            end
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else begin
            state <= IDLE;
         end
         if (!pc_write)
            stall_count <= sat_inc(stall_count);
      end
   end

   assign hz.pcWrite     = pc_write;
   assign hz.IFIDWrite   = ifid_write;
   assign hz.IFIDFlush   = ifid_flush;
   assign hz.IDEXWrite   = idex_write;
   assign hz.IDEXBubble  = idex_bubble;
   assign hz.EXMEMBubble = exmem_bubble;
   assign hz.mdBusy      = (state == BUSY);
   assign hz.hiloWrite   = hilo_write;
   assign hz.stallCount  = stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LAT=4 and a 4-bit stall counter.
module tb_hazard_stall_ctrl;

   logic clk;
   logic rst;
   int   tests;
   int   failed;
   int   n_freeze;
   int   n_hilo;

   hazard_stall_if #(.CNT_W(4)) hz ();

   hazard_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic set_in(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                         input logic [4:0] rt_id, input logic uses_rt, input logic br,
                         input logic md);
      hz.IDEXMemRead    = mr;
      hz.IDEXRegisterRt = rt_ex;
      hz.IFIDRegisterRs = rs_id;
      hz.IFIDRegisterRt = rt_id;
      hz.IFIDUsesRt     = uses_rt;
      hz.branchTaken    = br;
      hz.IDEXMdStart    = md;
   endtask

   initial begin
      tests  = 0;
      failed = 0;

      // Reset with every hazard input active, before any clock edge.
      rst = 1'b1;
      set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
      #1;
      check("rst_pcWrite", 32'(hz.pcWrite), 32'd1);
      check("rst_mdBusy", 32'(hz.mdBusy), 32'd0);
      check("rst_stallCount", 32'(hz.stallCount), 32'd0);
      check("rst_hilo", 32'(hz.hiloWrite), 32'd0);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Load-use on rs: one stall cycle, then the load has moved on.
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("lu_pcWrite", 32'(hz.pcWrite), 32'd0);
      check("lu_IFIDWrite", 32'(hz.IFIDWrite), 32'd0);
      check("lu_IDEXBubble", 32'(hz.IDEXBubble), 32'd1);
      check("lu_IDEXWrite", 32'(hz.IDEXWrite), 32'd1);
      tick();
      hz.IDEXMemRead = 1'b0;
      #1;
      check("lu_after_pcWrite", 32'(hz.pcWrite), 32'd1);
      check("lu_after_bubble", 32'(hz.IDEXBubble), 32'd0);
      check("lu_stallCount", 32'(hz.stallCount), 32'd1);

      // Register 0 never stalls.
      set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      check("r0_pcWrite", 32'(hz.pcWrite), 32'd1);

      // rt-only match depends on IFIDUsesRt; branch is held off by the stall.
      set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
      #1;
      check("rt_nouse_pcWrite", 32'(hz.pcWrite), 32'd1);
      hz.IFIDUsesRt = 1'b1;
      #1;
      check("rt_use_pcWrite", 32'(hz.pcWrite), 32'd0);
      hz.branchTaken = 1'b1;
      #1;
      check("rt_br_flush", 32'(hz.IFIDFlush), 32'd0);
      check("rt_br_bubble", 32'(hz.IDEXBubble), 32'd1);
      tick();
      check("rt_stallCount", 32'(hz.stallCount), 32'd2);
      hz.IDEXMemRead = 1'b0;
      hz.IFIDUsesRt  = 1'b0;
      #1;
      check("br_flush", 32'(hz.IFIDFlush), 32'd1);
      check("br_pcWrite", 32'(hz.pcWrite), 32'd1);
      check("br_IFIDWrite", 32'(hz.IFIDWrite), 32'd1);

      // Asynchronous reset mid-cycle clears the counter.
      rst_pulse();
      #1;
      check("arst_stallCount", 32'(hz.stallCount), 32'd0);

      // Single mult/div: three freeze cycles masking load-use and branch, then hiloWrite.
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
      #1;
      check("md1_pcWrite", 32'(hz.pcWrite), 32'd0);
      check("md1_exmem", 32'(hz.EXMEMBubble), 32'd1);
      check("md1_flush", 32'(hz.IFIDFlush), 32'd0);
      check("md1_idexbub", 32'(hz.IDEXBubble), 32'd0);
      check("md1_idexwr", 32'(hz.IDEXWrite), 32'd0);
      check("md1_mdBusy", 32'(hz.mdBusy), 32'd0);
      tick();
      hz.IDEXMemRead = 1'b0;
      #1;
      check("md2_mdBusy", 32'(hz.mdBusy), 32'd1);
      check("md2_pcWrite", 32'(hz.pcWrite), 32'd0);
      check("md2_hilo", 32'(hz.hiloWrite), 32'd0);
      tick();
      check("md3_pcWrite", 32'(hz.pcWrite), 32'd0);
      check("md3_hilo", 32'(hz.hiloWrite), 32'd0);
      tick();
      check("md4_hilo", 32'(hz.hiloWrite), 32'd1);
      check("md4_pcWrite", 32'(hz.pcWrite), 32'd1);
      check("md4_exmem", 32'(hz.EXMEMBubble), 32'd0);
      check("md4_flush", 32'(hz.IFIDFlush), 32'd1);
      check("md4_stallCount", 32'(hz.stallCount), 32'd3);
      hz.IDEXMdStart = 1'b0;
      hz.branchTaken = 1'b0;
      tick();
      check("md_done_hilo", 32'(hz.hiloWrite), 32'd0);
      check("md_done_busy", 32'(hz.mdBusy), 32'd0);
      check("md_done_stallCount", 32'(hz.stallCount), 32'd3);

      // Back-to-back mult/div with no idle gap.
      rst_pulse();
      n_freeze = 0;
      n_hilo   = 0;
      hz.IDEXMdStart = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!hz.pcWrite) n_freeze++;
         if (hz.hiloWrite) n_hilo++;
         tick();
      end
      hz.IDEXMdStart = 1'b0;
      #1;
      check("b2b_freeze", 32'(n_freeze), 32'd6);
      check("b2b_hilo", 32'(n_hilo), 32'd2);
      check("b2b_stallCount", 32'(hz.stallCount), 32'd6);
      check("b2b_mdBusy", 32'(hz.mdBusy), 32'd0);

      // Reset in the second BUSY cycle drops the freeze at once and never commits.
      rst_pulse();
      hz.IDEXMdStart = 1'b1;
      #1;
      tick();
      tick();
      check("mrst_busy_before", 32'(hz.mdBusy), 32'd1);
      check("mrst_pc_before", 32'(hz.pcWrite), 32'd0);
      rst = 1'b1;
      #1;
      check("mrst_pcWrite", 32'(hz.pcWrite), 32'd1);
      check("mrst_mdBusy", 32'(hz.mdBusy), 32'd0);
      check("mrst_hilo", 32'(hz.hiloWrite), 32'd0);
      hz.IDEXMdStart = 1'b0;
      rst = 1'b0;
      n_hilo = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (hz.hiloWrite) n_hilo++;
      end
      check("mrst_no_hilo", 32'(n_hilo), 32'd0);
      check("mrst_pc_after", 32'(hz.pcWrite), 32'd1);

      // Stall counter saturates at 15 with a 4-bit width.
      rst_pulse();
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (14) tick();
      check("sat_14", 32'(hz.stallCount), 32'd14);
      repeat (6) tick();
      check("sat_15", 32'(hz.stallCount), 32'd15);
      check("sat_pcWrite", 32'(hz.pcWrite), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
